// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 ALU decode stage.
// The illegal flag is carried in dec_beat_t only when RV32_DEC_ILLEGAL_EN is defined.
package rv32_pkg;

   typedef enum logic [3:0] {
      AluAdd   = 4'd0,
      AluSub   = 4'd1,
      AluAnd   = 4'd2,
      AluOr    = 4'd3,
      AluXor   = 4'd4,
      AluSlt   = 4'd5,
      AluSltu  = 4'd6,
      AluAddi  = 4'd7,
      AluRsvd  = 4'd8,
      AluAndi  = 4'd9,
      AluOri   = 4'd10,
      AluXori  = 4'd11,
      AluSlti  = 4'd12,
      AluSltiu = 4'd13,
      AluLui   = 4'd14,
      AluAuipc = 4'd15
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      alu_op_e     alu_opsel;
      logic        enable;
      logic        rd_we;
`ifdef RV32_DEC_ILLEGAL_EN
      logic        illegal;
`endif
   } dec_beat_t;

endpackage

// File: rtl/rv32_alu_opdec.sv
// Combinational decoder: instruction word to ALU op select, enable, rd write enable
// and illegal flag for the R-type / OP-IMM / LUI / AUIPC subset.
module rv32_alu_opdec
   import rv32_pkg::*;
(
   input  logic [31:0] i_instr,
   output alu_op_e     o_alu_opsel,
   output logic        o_enable,
   output logic        o_rd_we,
   output logic        o_illegal
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic [4:0] w_rd;
   alu_op_e    w_op;
   logic       w_legal;
   logic       w_unused;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];
   assign w_rd     = i_instr[11:7];
   assign w_unused = ^i_instr[24:15];

   always_comb begin
      w_op    = AluAdd;
      w_legal = 1'b0;
      case (w_opcode)
         OPC_OP: begin
            if (w_funct7 == F7_BASE) begin
               w_legal = 1'b1;
               case (w_funct3)
                  3'b000:  w_op = AluAdd;
                  3'b111:  w_op = AluAnd;
                  3'b110:  w_op = AluOr;
                  3'b100:  w_op = AluXor;
                  3'b010:  w_op = AluSlt;
                  3'b011:  w_op = AluSltu;
                  default: w_legal = 1'b0;
               endcase
            end else if (w_funct7 == F7_SUB && w_funct3 == 3'b000) begin
               w_legal = 1'b1;
               w_op    = AluSub;
            end
         end
         OPC_OP_IMM: begin
            w_legal = 1'b1;
            case (w_funct3)
               3'b000:  w_op = AluAddi;
               3'b111:  w_op = AluAndi;
               3'b110:  w_op = AluOri;
               3'b100:  w_op = AluXori;
               3'b010:  w_op = AluSlti;
               3'b011:  w_op = AluSltiu;
               default: w_legal = 1'b0;  // shifts are not supported by this ALU
            endcase
         end
         OPC_LUI: begin
            w_legal = 1'b1;
            w_op    = AluLui;
         end
         OPC_AUIPC: begin
            w_legal = 1'b1;
            w_op    = AluAuipc;
         end
         default: ;
      endcase
   end

   assign o_alu_opsel = w_legal ? w_op : AluAdd;
   assign o_enable    = w_legal;
   assign o_rd_we     = w_legal & (|w_rd);
   assign o_illegal   = ~w_legal;

endmodule

// File: rtl/rv32_alu_decode.sv
// Decode stage with a two-entry skid buffer between fetch and the RV32 ALU.
// RV32_DEC_ILLEGAL_EN forwards illegal words with o_illegal=1; otherwise they are dropped.
module rv32_alu_decode
   import rv32_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_if_valid,
   output logic        o_if_ready,
   input  logic [31:0] i_if_instr,
   input  logic [31:0] i_if_pc,
   input  logic        i_flush,
   output logic        o_ex_valid,
   input  logic        i_ex_ready,
   output logic [31:0] o_code_bus,
   output logic [31:0] o_pc,
   output logic [3:0]  o_alu_opsel,
   output logic        o_enable,
   output logic [4:0]  o_rs1_addr,
   output logic [4:0]  o_rs2_addr,
   output logic [4:0]  o_rd_addr,
`ifdef RV32_DEC_ILLEGAL_EN
   output logic        o_illegal,
`endif
   output logic        o_rd_we
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e    r_state;
   dec_beat_t r_main;
   dec_beat_t r_skid;
   dec_beat_t w_beat;
   alu_op_e   w_opsel;
   logic      w_enable;
   logic      w_rd_we;
   logic      w_illegal;
   logic      w_accept;
   logic      w_load;

   rv32_alu_opdec u_opdec (
      .i_instr     (i_if_instr),
      .o_alu_opsel (w_opsel),
      .o_enable    (w_enable),
      .o_rd_we     (w_rd_we),
      .o_illegal   (w_illegal)
   );

   always_comb begin
      w_beat           = '0;
      w_beat.instr     = i_if_instr;
      w_beat.pc        = i_if_pc;
      w_beat.alu_opsel = w_opsel;
      w_beat.enable    = w_enable;
      w_beat.rd_we     = w_rd_we;
`ifdef RV32_DEC_ILLEGAL_EN
      w_beat.illegal   = w_illegal;
`endif
   end

   assign o_if_ready = (r_state != StTwo) & ~i_rst;
   assign w_accept   = i_if_valid & o_if_ready;
`ifdef RV32_DEC_ILLEGAL_EN
   assign w_load     = w_accept;
`else
   // Illegal words complete the handshake but never enter the buffer.
   assign w_load     = w_accept & ~w_illegal;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StEmpty;
         r_main  <= '0;
         r_skid  <= '0;
      end else if (i_flush) begin
         r_state <= StEmpty;
      end else begin
         case (r_state)
            StEmpty: begin
               if (w_load) begin
                  r_main  <= w_beat;
                  r_state <= StOne;
               end
            end
            StOne: begin
               if (w_load && i_ex_ready) begin
                  r_main <= w_beat;
               end else if (w_load) begin
                  r_skid  <= w_beat;
                  r_state <= StTwo;
               end else if (i_ex_ready) begin
                  r_state <= StEmpty;
               end
            end
            StTwo: begin
               if (i_ex_ready) begin
                  r_main  <= r_skid;
                  r_state <= StOne;
               end
            end
            default: r_state <= StEmpty;
         endcase
      end
   end

   assign o_ex_valid  = (r_state != StEmpty);
   assign o_code_bus  = r_main.instr;
   assign o_pc        = r_main.pc;
   assign o_alu_opsel = r_main.alu_opsel;
   assign o_enable    = r_main.enable;
   assign o_rd_we     = r_main.rd_we;
   assign o_rs1_addr  = r_main.instr[19:15];
   assign o_rs2_addr  = r_main.instr[24:20];
   assign o_rd_addr   = r_main.instr[11:7];
`ifdef RV32_DEC_ILLEGAL_EN
   assign o_illegal   = r_main.illegal;
`endif

endmodule

// File: tb/tb_rv32_alu_decode.sv
// Directed self-checking bench for rv32_alu_decode; handles RV32_DEC_ILLEGAL_EN either way.
module tb_rv32_alu_decode;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_if_valid;
   logic        o_if_ready;
   logic [31:0] i_if_instr;
   logic [31:0] i_if_pc;
   logic        i_flush;
   logic        o_ex_valid;
   logic        i_ex_ready;
   logic [31:0] o_code_bus;
   logic [31:0] o_pc;
   logic [3:0]  o_alu_opsel;
   logic        o_enable;
   logic [4:0]  o_rs1_addr;
   logic [4:0]  o_rs2_addr;
   logic [4:0]  o_rd_addr;
   logic        o_rd_we;
`ifdef RV32_DEC_ILLEGAL_EN
   logic        o_illegal;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] I_ADD0  = 32'h0020_8033;
   localparam logic [31:0] I_ADDI  = 32'h0010_0093;
   localparam logic [31:0] I_AND   = 32'h0020_F1B3;
   localparam logic [31:0] I_OR    = 32'h0020_E233;
   localparam logic [31:0] I_SLT   = 32'h0020_A2B3;
   localparam logic [31:0] I_SLLI  = 32'h0010_9093;

   always #5 i_clk = ~i_clk;

   rv32_alu_decode dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_if_valid  (i_if_valid),
      .o_if_ready  (o_if_ready),
      .i_if_instr  (i_if_instr),
      .i_if_pc     (i_if_pc),
      .i_flush     (i_flush),
      .o_ex_valid  (o_ex_valid),
      .i_ex_ready  (i_ex_ready),
      .o_code_bus  (o_code_bus),
      .o_pc        (o_pc),
      .o_alu_opsel (o_alu_opsel),
      .o_enable    (o_enable),
      .o_rs1_addr  (o_rs1_addr),
      .o_rs2_addr  (o_rs2_addr),
      .o_rd_addr   (o_rd_addr),
`ifdef RV32_DEC_ILLEGAL_EN
      .o_illegal   (o_illegal),
`endif
      .o_rd_we     (o_rd_we)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      i_if_valid = v;
      i_if_instr = instr;
      i_if_pc    = pc;
   endtask

   logic [31:0] b2b_instr [4];
   logic [3:0]  b2b_op    [4];
   logic [4:0]  b2b_rd    [4];

   initial begin
      b2b_instr = '{32'h4020_8133, 32'hFFF0_C093, 32'h1234_50B7, 32'h0000_1117};
      b2b_op    = '{4'd1, 4'd11, 4'd14, 4'd15};
      b2b_rd    = '{5'd2, 5'd1, 5'd1, 5'd2};

      i_rst = 1'b1; i_flush = 1'b0; i_ex_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      @(posedge i_clk); #1;
      cyc();
      check_eq("rst_if_ready",  {31'b0, o_if_ready}, 32'd0);
      check_eq("rst_ex_valid",  {31'b0, o_ex_valid}, 32'd0);
      check_eq("rst_code_bus",  o_code_bus, 32'd0);
      check_eq("rst_opsel",     {28'b0, o_alu_opsel}, 32'd0);
      check_eq("rst_enable",    {31'b0, o_enable}, 32'd0);
      i_rst = 1'b0;
      cyc();
      check_eq("post_rst_if_ready", {31'b0, o_if_ready}, 32'd1);

      // add x0,x1,x2
      drive(1'b1, I_ADD0, 32'h100);
      cyc();
      check_eq("add_ex_valid", {31'b0, o_ex_valid}, 32'd1);
      check_eq("add_opsel",    {28'b0, o_alu_opsel}, 32'd0);
      check_eq("add_enable",   {31'b0, o_enable}, 32'd1);
      check_eq("add_rd_we",    {31'b0, o_rd_we}, 32'd0);
      check_eq("add_rs1",      {27'b0, o_rs1_addr}, 32'd1);
      check_eq("add_rs2",      {27'b0, o_rs2_addr}, 32'd2);
      check_eq("add_pc",       o_pc, 32'h100);

      // back-to-back with ex_ready held high
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, b2b_instr[i], 32'h104 + 32'(4 * i));
         cyc();
         check_eq($sformatf("b2b%0d_valid", i), {31'b0, o_ex_valid}, 32'd1);
         check_eq($sformatf("b2b%0d_opsel", i), {28'b0, o_alu_opsel}, {28'b0, b2b_op[i]});
         check_eq($sformatf("b2b%0d_rd", i), {27'b0, o_rd_addr}, {27'b0, b2b_rd[i]});
         check_eq($sformatf("b2b%0d_rd_we", i), {31'b0, o_rd_we}, 32'd1);
         check_eq($sformatf("b2b%0d_ready", i), {31'b0, o_if_ready}, 32'd1);
      end
      drive(1'b0, 32'h0, 32'h0);
      cyc();
      check_eq("drain_ex_valid", {31'b0, o_ex_valid}, 32'd0);

      // stall: two accepts fill the buffer, then in-order release
      i_ex_ready = 1'b0;
      drive(1'b1, I_ADDI, 32'h200);
      cyc();
      check_eq("stall_a_ready", {31'b0, o_if_ready}, 32'd1);
      drive(1'b1, I_AND, 32'h204);
      cyc();
      check_eq("stall_b_ready", {31'b0, o_if_ready}, 32'd0);
      check_eq("stall_b_opsel", {28'b0, o_alu_opsel}, 32'd7);
      drive(1'b1, I_OR, 32'h208);
      cyc();
      check_eq("stall_hold_ready", {31'b0, o_if_ready}, 32'd0);
      check_eq("stall_hold_code",  o_code_bus, I_ADDI);
      i_ex_ready = 1'b1;
      cyc();
      check_eq("rel_b_opsel", {28'b0, o_alu_opsel}, 32'd2);
      check_eq("rel_b_pc",    o_pc, 32'h204);
      check_eq("rel_b_ready", {31'b0, o_if_ready}, 32'd1);
      cyc();
      check_eq("rel_c_opsel", {28'b0, o_alu_opsel}, 32'd3);
      check_eq("rel_c_code",  o_code_bus, I_OR);
      drive(1'b1, I_SLT, 32'h20C);
      cyc();
      check_eq("rel_d_opsel", {28'b0, o_alu_opsel}, 32'd5);
      drive(1'b0, 32'h0, 32'h0);
      cyc();
      check_eq("rel_end_valid", {31'b0, o_ex_valid}, 32'd0);

      // slli is illegal for this ALU
      drive(1'b1, I_SLLI, 32'h300);
      cyc();
`ifdef RV32_DEC_ILLEGAL_EN
      check_eq("slli_valid",   {31'b0, o_ex_valid}, 32'd1);
      check_eq("slli_illegal", {31'b0, o_illegal}, 32'd1);
      check_eq("slli_enable",  {31'b0, o_enable}, 32'd0);
      check_eq("slli_opsel",   {28'b0, o_alu_opsel}, 32'd0);
      check_eq("slli_rd_we",   {31'b0, o_rd_we}, 32'd0);
`else
      check_eq("slli_dropped", {31'b0, o_ex_valid}, 32'd0);
      check_eq("slli_ready",   {31'b0, o_if_ready}, 32'd1);
`endif
      drive(1'b1, I_ADDI, 32'h304);
      cyc();
      check_eq("post_slli_valid", {31'b0, o_ex_valid}, 32'd1);
      check_eq("post_slli_code",  o_code_bus, I_ADDI);
      check_eq("post_slli_opsel", {28'b0, o_alu_opsel}, 32'd7);
`ifdef RV32_DEC_ILLEGAL_EN
      check_eq("post_slli_illegal", {31'b0, o_illegal}, 32'd0);
`endif
      drive(1'b0, 32'h0, 32'h0);
      cyc();

      // flush while in TWO with a beat on the input
      i_ex_ready = 1'b0;
      drive(1'b1, I_AND, 32'h400);
      cyc();
      drive(1'b1, I_OR, 32'h404);
      cyc();
      check_eq("pre_flush_ready", {31'b0, o_if_ready}, 32'd0);
      drive(1'b1, I_SLT, 32'h408);
      i_flush = 1'b1;
      cyc();
      check_eq("flush_valid", {31'b0, o_ex_valid}, 32'd0);
      check_eq("flush_ready", {31'b0, o_if_ready}, 32'd1);
      check_eq("flush_hold",  o_code_bus, I_AND);
      i_flush = 1'b0;
      i_ex_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      cyc();
      check_eq("flush_gone", {31'b0, o_ex_valid}, 32'd0);

      // reset while in ONE
      drive(1'b1, I_AND, 32'h500);
      cyc();
      check_eq("pre_rst_valid", {31'b0, o_ex_valid}, 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      i_rst = 1'b1;
      i_ex_ready = 1'b0;
      cyc();
      check_eq("mid_rst_valid", {31'b0, o_ex_valid}, 32'd0);
      check_eq("mid_rst_code",  o_code_bus, 32'd0);
      check_eq("mid_rst_pc",    o_pc, 32'd0);
      check_eq("mid_rst_opsel", {28'b0, o_alu_opsel}, 32'd0);
      check_eq("mid_rst_en",    {31'b0, o_enable}, 32'd0);
      check_eq("mid_rst_rd",    {27'b0, o_rd_addr}, 32'd0);
      check_eq("mid_rst_rd_we", {31'b0, o_rd_we}, 32'd0);
      check_eq("mid_rst_ready", {31'b0, o_if_ready}, 32'd0);
      i_rst = 1'b0;
      cyc();
      check_eq("post_mid_rst_ready", {31'b0, o_if_ready}, 32'd1);
      check_eq("post_mid_rst_valid", {31'b0, o_ex_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32_alu_decode.md
# rv32_alu_decode

Decode stage feeding the RV32 ALU: accepts fetched instructions over a valid/ready handshake and decodes the integer ALU subset (R-type, OP-IMM, LUI, AUIPC) into the ALU's `alu_opsel`/`enable`/`code_bus`/`pc` operand interface. It also produces register-file addresses and write enables. A two-entry skid buffer gives full throughput with registered outputs and a registered `if_ready`. The block sits between fetch and the execute/ALU stage.

## Interface
- No parameters; widths fixed at RV32.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `if_valid`  in  1  fetch beat valid
- `if_ready`  out  1  decode can accept
- `if_instr`  in  32  instruction word
- `if_pc`  in  32  instruction address
- `flush`  in  1  discard all held and incoming beats
- `ex_valid`  out  1  decoded beat valid
- `ex_ready`  in  1  execute consumes beat
- `code_bus`  out  32  instruction word, passed to ALU
- `pc`  out  32  instruction address, passed to ALU
- `alu_opsel`  out  4  ALU operation select
- `enable`  out  1  legal ALU instruction
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5 each  `instr[19:15]`, `[24:20]`, `[11:7]`
- `rd_we`  out  1  register write enable
- `illegal`  out  1  present only with `RV32_DEC_ILLEGAL_EN`

## Operation
- `alu_opsel` encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU
  - 7 ADDI, 8 never emitted
  - 9 ANDI, 10 ORI, 11 XORI, 12 SLTI, 13 SLTIU
  - 14 LUI, 15 AUIPC
- Opcode `0110011`:
  - funct7 `0000000`: funct3 000→0, 111→2, 110→3, 100→4, 010→5, 011→6.
  - funct7 `0100000`: funct3 000→1.
  - Any other funct7/funct3 combination is illegal.
- Opcode `0010011`: funct3 000→7, 111→9, 110→10, 100→11, 010→12, 011→13. Shifts (funct3 001/101) are illegal.
- Opcode `0110111`→14. Opcode `0010111`→15. All other opcodes are illegal.
- Legal instruction: `enable`=1, `rd_we`=(rd≠0).
- Illegal instruction: `enable`=0, `alu_opsel`=0, `rd_we`=0.
- Skid FSM has three states:
  - EMPTY: accept → ONE.
  - ONE: accept & `ex_ready` → ONE (main register replaced); accept & !`ex_ready` → TWO (beat goes to skid register); no accept & `ex_ready` → EMPTY.
  - TWO: `ex_ready` → ONE (skid register moves to main, in order).
- Accept = `if_valid` & `if_ready`.
- `if_ready` = !skid_valid & !`rst`.
- `ex_valid` = state≠EMPTY.
- Beat order is strictly preserved.

## Timing
- Latency: an accepted beat appears on `ex_*` the next cycle when the FSM was EMPTY, or when it was ONE with `ex_ready` high.
- Throughput: one beat per cycle while `ex_ready` is held high.
- `if_ready` depends only on registered state (and `rst`); there is no combinational path from `ex_ready` to `if_ready`.
- Output payload changes only when a new beat loads the main register. While `ex_valid`=1 and `ex_ready`=0, the payload is stable.
- `flush`:
  - Next state is EMPTY; the input beat in the same cycle is discarded.
  - `if_ready` is high the next cycle.
  - Payload outputs hold their values.
- Priority: `rst` > `flush` > handshake.
- Reset values: `ex_valid`=0, `code_bus`=0, `pc`=0, `alu_opsel`=0, `enable`=0, all addresses 0, `rd_we`=0, `illegal`=0. `if_ready` is 0 while `rst` is high and 1 the cycle after.
- Reset mid-stream drops every held beat.

## Configuration
- `RV32_DEC_ILLEGAL_EN` defined:
  - Illegal words are forwarded as normal beats with `illegal`=1, `enable`=0, `rd_we`=0.
  - `illegal` travels with the beat through the skid register.
- `RV32_DEC_ILLEGAL_EN` undefined:
  - The `illegal` port is absent.
  - Illegal words are accepted (handshake completes) and dropped; no `ex_valid` beat is produced and FSM state is unchanged by that beat.

## Structure
- Shared package `rv32_pkg`:
  - `alu_op_e` (4-bit enum, values above).
  - Opcode constants `OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`.
  - funct7 constants `F7_BASE`, `F7_SUB`.
  - Decoded-beat struct `dec_beat_t`.
- Sub-module `rv32_alu_opdec`: purely combinational; maps `instr` to `alu_opsel`, `enable`, `rd_we`, `illegal`. It is instantiated once, on the input side; both storage registers hold `dec_beat_t`.

## Test plan
- Reset, then `0x00208033` (add x0,x1,x2) with `ex_ready`=1 → next cycle `ex_valid`=1, `alu_opsel`=0, `enable`=1, `rd_we`=0.
- Back-to-back `0x40208133` (sub), `0xFFF0C093` (xori x1,x1,-1), `0x123450B7` (lui), `0x00001117` (auipc), `ex_ready`=1 → opsel 1, 11, 14, 15 on consecutive cycles; no bubbles.
- Stream 4 beats with `ex_ready`=0 → `if_ready` drops after two accepts; releasing `ex_ready` delivers the beats in order; no loss or duplication.
- `0x00109093` (slli) → with the macro: one beat, `illegal`=1, `enable`=0, `alu_opsel`=0. Without the macro: no `ex_valid` beat, and the next legal instruction emerges normally.
- FSM in TWO, assert `flush` together with an incoming beat → next cycle `ex_valid`=0, `if_ready`=1; the incoming beat never appears.
- Assert `rst` while in ONE → all outputs at reset values the next cycle.
